// File: rtl/gf233_reducer.sv
// Reducer for GF(2^233), f(x) = x^233 + x^74 + 1, folding from the top bit down.
// Define GF233_RED_DUAL_EN to fold two bits per clock (half the run length).
module gf233_reducer #(
    parameter int N = 233,
    parameter int K = 74
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-2:0]   in_poly,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_m,
    output logic             busy
);

    localparam int W  = 2 * N - 1;
    localparam int IW = $clog2(W);

    localparam logic [IW-1:0] TOP = IW'(W - 1);

`ifdef GF233_RED_DUAL_EN
    localparam logic [IW-1:0] STEP = IW'(2);
    localparam logic [IW-1:0] LAST = IW'(N + 1);
`else
    localparam logic [IW-1:0] STEP = IW'(1);
    localparam logic [IW-1:0] LAST = IW'(N);
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  r, r_nx;
    logic [IW-1:0] idx, idx_nx;

    // x^i = x^(i-159) + x^(i-233) mod f; the mask also clears bit i itself.
    function automatic logic [W-1:0] fold(
        input logic [W-1:0]  v,
        input logic [IW-1:0] i
    );
        logic [W-1:0] hot;
        hot = {{(W-1){1'b0}}, 1'b1} << i;
        if (v[i])
            fold = v ^ hot ^ (hot >> (N - K)) ^ (hot >> N);
        else
            fold = v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            r     <= r_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        r_nx     = r;
        idx_nx   = idx;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    r_nx     = in_poly;
                    idx_nx   = TOP;
                    state_nx = RUN;
                end
            end
            RUN: begin
`ifdef GF233_RED_DUAL_EN
                r_nx = fold(fold(r, idx), idx - IW'(1));
`else
                r_nx = fold(r, idx);
`endif
                idx_nx = idx - STEP;
                if (idx == LAST)
                    state_nx = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Low half of r is the result in DONE and stays put through IDLE.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign out_m     = r[N-1:0];

endmodule

// File: tb/tb_gf233_reducer.sv
// Directed bench for gf233_reducer: latency, handshake, reset and fold results.
module tb_gf233_reducer;

    localparam int N = 233;
    localparam int W = 2 * N - 1;
`ifdef GF233_RED_DUAL_EN
    localparam int LAT = 117;
`else
    localparam int LAT = 233;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_poly;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_m;
    logic         busy;

    int errors;
    int checks;
    int edges;

    gf233_reducer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_poly   (in_poly),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_m     (out_m),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference by whole-word folding: hi*x^233 -> hi*x^74 + hi.
    function automatic logic [N-1:0] ref_mod(input logic [W-1:0] p);
        logic [W-1:0] v;
        logic [W-1:0] h;
        logic [W-1:0] lo;
        lo = '0;
        lo[N-1:0] = '1;
        v = p;
        for (int it = 0; it < 4; it++) begin
            h = v >> N;
            v = (v & lo) ^ (h << 74) ^ h;
        end
        return v[N-1:0];
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [479:0] t;
        for (int i = 0; i < 15; i++)
            t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic start(input logic [W-1:0] p);
        @(negedge clk);
        in_valid = 1'b1;
        in_poly  = p;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_poly  = ~p;
    endtask

    task automatic wait_done(input string tag);
        edges = 1;
        chk({tag, "_busy"}, W'(busy), W'(1));
        while (!out_valid && edges < 400) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        chk({tag, "_lat"}, W'(edges), W'(LAT));
    endtask

    task automatic finish_op(input string tag, input logic [N-1:0] e);
        chk({tag, "_m"}, W'(out_m), W'(e));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rdy"}, W'(in_ready), W'(1));
        chk({tag, "_ov"}, W'(out_valid), W'(0));
        chk({tag, "_hold"}, W'(out_m), W'(e));
    endtask

    task automatic op(input string tag, input logic [W-1:0] p,
                      input logic [N-1:0] e);
        start(p);
        wait_done(tag);
        finish_op(tag, e);
    endtask

    logic [W-1:0] p;
    logic [N-1:0] e;
    logic [W-1:0] lo;

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_poly   = '0;
        lo        = '0;
        lo[N-1:0] = '1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_out_m", W'(out_m), W'(0));
        rst_n = 1'b1;

        op("clmul30", W'(30), N'(30));

        p = W'(1) << 233;
        e = (N'(1) << 74) | N'(1);
        op("x233", p, e);

        op("zero", '0, '0);

        p = rnd() & lo;
        op("passthru", p, p[N-1:0]);

        // x^464 with DONE held for 10 cycles and a stray in_valid pulse.
        p = W'(1) << 464;
        e = (N'(1) << 231) | (N'(1) << 146) | (N'(1) << 72);
        start(p);
        wait_done("x464");
        for (int c = 0; c < 10; c++) begin
            chk("hold_ov", W'(out_valid), W'(1));
            chk("hold_m", W'(out_m), W'(e));
            chk("hold_in_ready", W'(in_ready), W'(0));
            in_valid = (c == 4);
            in_poly  = rnd();
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("hold_busy", W'(busy), W'(0));
        finish_op("x464", e);

        // Reset deep inside RUN abandons the operation.
        start(W'(1) << 464);
        repeat (99) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", W'(out_valid), W'(0));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_rdy", W'(in_ready), W'(1));
        chk("mid_rst_m", W'(out_m), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        p = rnd();
        op("after_rst", p, ref_mod(p));

        for (int k = 0; k < 4; k++) begin
            p = rnd();
            op($sformatf("rand%0d", k), p, ref_mod(p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
